// File: rtl/dragonfang_pkg.sv
// Shared types and sizing for the dragonfang vector pipeline.
// Holds the write-back packet format and the register-file and queue dimensions.
package dragonfang_pkg;

    localparam int VREG_COUNT     = 32;
    localparam int VREG_TAG_WIDTH = $clog2(VREG_COUNT);
    localparam int WB_QUEUE_DEPTH = 4;
    localparam int WB_DATA_WIDTH  = 64;

    // Merged result leaving vector_write_back: destination vreg plus data
    typedef struct packed {
        logic [VREG_TAG_WIDTH-1:0] tag;
        logic [WB_DATA_WIDTH-1:0]  data;
    } data_packet_t;

endpackage

// File: rtl/vector_fifo_core.sv
// Generic circular-buffer FIFO: storage, wrap-bit pointers, full/empty, count.
// Also exposes every slot and an occupancy mask so callers can scan live entries.
module vector_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            write_data,
    output logic [WIDTH-1:0]            read_data,
    output logic [DEPTH-1:0][WIDTH-1:0] entries,
    output logic [DEPTH-1:0]            occupied,
    output logic                        empty,
    output logic                        full,
    output logic [AW:0]                 count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;

    // Pointer update; flush collapses the read pointer onto the write pointer and drops any push
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents carry no reset since only occupied slots are ever observed
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= write_data;
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;
    assign read_data = mem[rd_ptr[AW-1:0]];
    assign entries   = mem;

    // A slot is live when its distance from the head is below the occupancy count
    always_comb begin
        logic [AW-1:0] offset;
        offset   = '0;
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = AW'(i) - rd_ptr[AW-1:0];
            occupied[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/vector_write_back_queue.sv
// In-order buffer between vector_write_back and the vector register file write port.
// Drains one packet per cycle under valid/ready and publishes a pending-destination mask.
// Optional zero-latency bypass when empty: define VECTOR_WRITE_BACK_QUEUE_BYPASS_EN.
module vector_write_back_queue
    import dragonfang_pkg::*;
#(
    parameter int DEPTH      = WB_QUEUE_DEPTH,
    parameter int VREG_COUNT = dragonfang_pkg::VREG_COUNT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      wb_valid,
    output logic                      wb_ready,
    input  data_packet_t              vd_write_back,
    output logic                      rf_write_enable,
    input  logic                      rf_write_ready,
    output logic [VREG_TAG_WIDTH-1:0] rf_write_address,
    output logic [63:0]               rf_write_data,
    output logic [VREG_COUNT-1:0]     busy_tags,
    output logic [$clog2(DEPTH):0]    pending_count
);

    localparam int PW = $bits(data_packet_t);

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     bypass_show;
    logic                     bypass_take;
    logic [PW-1:0]            head_bits;
    logic [DEPTH-1:0][PW-1:0] entry_bits;
    logic [DEPTH-1:0]         occupied;
    data_packet_t             head;

    vector_fifo_core #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .flush      (flush),
        .write_data (vd_write_back),
        .read_data  (head_bits),
        .entries    (entry_bits),
        .occupied   (occupied),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (pending_count)
    );

`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
    assign bypass_show = fifo_empty & wb_valid;
`else
    assign bypass_show = 1'b0;
`endif

    // A bypassed packet that the register file accepts immediately never enters storage
    assign bypass_take = bypass_show & rf_write_ready;

    assign head             = head_bits;
    assign wb_ready         = !fifo_full;
    assign fifo_push        = wb_valid & wb_ready & !bypass_take;
    assign fifo_pop         = !fifo_empty & rf_write_ready;
    assign rf_write_enable  = !fifo_empty | bypass_show;
    assign rf_write_address = bypass_show ? vd_write_back.tag  : head.tag;
    assign rf_write_data    = bypass_show ? vd_write_back.data : head.data;

    // Pending-destination mask: one-hot of every live entry's tag, plus a bypassing packet
    always_comb begin
        data_packet_t entry;
        entry     = '0;
        busy_tags = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry = entry_bits[i];
            if (occupied[i]) busy_tags = busy_tags | (VREG_COUNT'(1) << entry.tag);
        end
        if (bypass_show) busy_tags = busy_tags | (VREG_COUNT'(1) << vd_write_back.tag);
    end

endmodule

// File: tb/tb_vector_write_back_queue.sv
// Self-checking bench for vector_write_back_queue.
// Table rows carry per-cycle inputs and expected status; a queue scoreboard checks write order.
module tb_vector_write_back_queue;
    import dragonfang_pkg::*;

    localparam int DEPTH = 4;

    logic         clock;
    logic         reset_n;
    logic         flush;
    logic         wb_valid;
    logic         wb_ready;
    data_packet_t vd_write_back;
    logic         rf_write_enable;
    logic         rf_write_ready;
    logic [4:0]   rf_write_address;
    logic [63:0]  rf_write_data;
    logic [31:0]  busy_tags;
    logic [2:0]   pending_count;

    vector_write_back_queue #(
        .DEPTH      (DEPTH),
        .VREG_COUNT (32)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .flush            (flush),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .vd_write_back    (vd_write_back),
        .rf_write_enable  (rf_write_enable),
        .rf_write_ready   (rf_write_ready),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .busy_tags        (busy_tags),
        .pending_count    (pending_count)
    );

    typedef struct {
        logic        v;
        logic [4:0]  tag;
        logic        rdy;
        logic        fl;
        int          exp_cnt;
        logic [31:0] exp_busy;
    } vec_t;

    vec_t         vecs[$];
    data_packet_t model_q[$];
    int           total;
    int           bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop so the run always ends even if the clock loop misbehaves
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] make_data(input logic [4:0] t);
        return {27'h0A5A5A5, t, {8{t[3:0]}}};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic v, input logic [4:0] tag, input logic rdy, input logic fl,
                           input int exp_cnt, input logic [31:0] exp_busy);
        vec_t r;
        r.v = v; r.tag = tag; r.rdy = rdy; r.fl = fl; r.exp_cnt = exp_cnt; r.exp_busy = exp_busy;
        vecs.push_back(r);
    endtask

    task automatic apply_stimulus(input vec_t r);
        data_packet_t pkt;
        data_packet_t exp_pkt;
        logic         byp_case;
        logic         do_pop;
        logic         can_push;
        @(negedge clock);
        pkt.tag        = r.tag;
        pkt.data       = make_data(r.tag);
        wb_valid       = r.v;
        vd_write_back  = pkt;
        rf_write_ready = r.rdy;
        flush          = r.fl;
        #1;
`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
        byp_case = r.v && (model_q.size() == 0);
`else
        byp_case = 1'b0;
`endif
        check_output("pending_count", 64'(pending_count), 64'(r.exp_cnt));
        check_output("wb_ready", 64'(wb_ready), 64'(r.exp_cnt < DEPTH));
        check_output("busy_tags", 64'(busy_tags), 64'(r.exp_busy | (byp_case ? (32'd1 << r.tag) : 32'd0)));
        check_output("rf_write_enable", 64'(rf_write_enable), 64'((r.exp_cnt != 0) || byp_case));
        if (model_q.size() > 0) check_output("head_addr", 64'(rf_write_address), 64'(model_q[0].tag));
        can_push = r.v && (model_q.size() < DEPTH) && !(byp_case && r.rdy);
        do_pop   = r.rdy && ((model_q.size() > 0) || byp_case);
        if (do_pop) begin
            if (model_q.size() > 0) exp_pkt = model_q.pop_front();
            else                    exp_pkt = pkt;
            check_output("write_addr", 64'(rf_write_address), 64'(exp_pkt.tag));
            check_output("write_data", rf_write_data, exp_pkt.data);
        end
        if (r.fl) model_q.delete();
        else if (can_push) model_q.push_back(pkt);
        @(posedge clock);
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        flush          = 1'b0;
        wb_valid       = 1'b0;
        rf_write_ready = 1'b0;
        vd_write_back  = '0;

        // Fill to full with the register file stalled, then one refused push while popping
        add_vec(1, 5'd1, 0, 0, 0, 32'h0);
        add_vec(1, 5'd2, 0, 0, 1, 32'h2);
        add_vec(1, 5'd3, 0, 0, 2, 32'h6);
        add_vec(1, 5'd4, 0, 0, 3, 32'hE);
        add_vec(1, 5'd6, 0, 0, 4, 32'h1E);
        add_vec(1, 5'd6, 1, 0, 4, 32'h1E);
        // Ten simultaneous push/pop cycles across the pointer wrap
        add_vec(1, 5'd8,  1, 0, 3, 32'h1C);
        add_vec(1, 5'd9,  1, 0, 3, 32'h118);
        add_vec(1, 5'd10, 1, 0, 3, 32'h310);
        add_vec(1, 5'd11, 1, 0, 3, 32'h700);
        add_vec(1, 5'd12, 1, 0, 3, 32'hE00);
        add_vec(1, 5'd13, 1, 0, 3, 32'h1C00);
        add_vec(1, 5'd14, 1, 0, 3, 32'h3800);
        add_vec(1, 5'd15, 1, 0, 3, 32'h7000);
        add_vec(1, 5'd16, 1, 0, 3, 32'hE000);
        add_vec(1, 5'd17, 1, 0, 3, 32'h1C000);
        // Flush with a concurrent push of tag 7, then an idle cycle with ready high
        add_vec(1, 5'd7, 0, 1, 3, 32'h38000);
        add_vec(0, 5'd0, 1, 0, 0, 32'h0);
        // Duplicate tags
        add_vec(1, 5'd5, 0, 0, 0, 32'h0);
        add_vec(1, 5'd5, 0, 0, 1, 32'h20);
        add_vec(0, 5'd0, 1, 0, 2, 32'h20);
        add_vec(0, 5'd0, 1, 0, 1, 32'h20);
        // Single-entry push/pop replaces the head
        add_vec(1, 5'd20, 0, 0, 0, 32'h0);
        add_vec(1, 5'd21, 1, 0, 1, 32'h100000);
        add_vec(0, 5'd0,  1, 0, 1, 32'h200000);
        add_vec(0, 5'd0,  0, 0, 0, 32'h0);

        repeat (2) @(negedge clock);
        #1;
        check_output("reset_count", 64'(pending_count), 64'd0);
        check_output("reset_enable", 64'(rf_write_enable), 64'd0);
        check_output("reset_ready", 64'(wb_ready), 64'd1);
        check_output("reset_busy", 64'(busy_tags), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        // Asynchronous reset with two entries queued
        apply_stimulus('{1'b1, 5'd3, 1'b0, 1'b0, 0, 32'h0});
        apply_stimulus('{1'b1, 5'd4, 1'b0, 1'b0, 1, 32'h8});
        @(negedge clock);
        wb_valid       = 1'b0;
        rf_write_ready = 1'b0;
        #2;
        check_output("pre_reset_count", 64'(pending_count), 64'd2);
        reset_n = 1'b0;
        #1;
        check_output("async_enable", 64'(rf_write_enable), 64'd0);
        check_output("async_count", 64'(pending_count), 64'd0);
        check_output("async_ready", 64'(wb_ready), 64'd1);
        check_output("async_busy", 64'(busy_tags), 64'd0);
        model_q.delete();
        @(negedge clock);
        reset_n = 1'b1;

        // Minimum latency from push to register file write
        @(negedge clock);
        wb_valid           = 1'b1;
        vd_write_back.tag  = 5'd9;
        vd_write_back.data = make_data(5'd9);
        rf_write_ready     = 1'b1;
        #1;
`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
        check_output("lat0_enable", 64'(rf_write_enable), 64'd1);
        check_output("lat0_addr", 64'(rf_write_address), 64'd9);
        check_output("lat0_count", 64'(pending_count), 64'd0);
`else
        check_output("lat0_enable", 64'(rf_write_enable), 64'd0);
        check_output("lat0_count", 64'(pending_count), 64'd0);
`endif
        @(negedge clock);
        wb_valid = 1'b0;
        #1;
`ifdef VECTOR_WRITE_BACK_QUEUE_BYPASS_EN
        check_output("lat1_enable", 64'(rf_write_enable), 64'd0);
        check_output("lat1_count", 64'(pending_count), 64'd0);
`else
        check_output("lat1_enable", 64'(rf_write_enable), 64'd1);
        check_output("lat1_addr", 64'(rf_write_address), 64'd9);
        check_output("lat1_data", rf_write_data, make_data(5'd9));
        check_output("lat1_count", 64'(pending_count), 64'd1);
`endif
        @(negedge clock);
        #1;
        check_output("drained_count", 64'(pending_count), 64'd0);
        check_output("drained_enable", 64'(rf_write_enable), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_write_back_queue.md
Name: vector_write_back_queue

Overview:
- Sits directly downstream of vector_write_back and buffers its merged vd_write_back packets in order.
- Drains them one per cycle into the vector register file write port under a valid/ready handshake.
- Absorbs cycles where the register file port is stalled, for example by read priority.
- Publishes a pending-destination bitmask that issue logic uses for RAW/WAW hazard checks.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- VREG_COUNT, 32, number of architectural vector registers; the width of busy_tags.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all queued entries.
- wb_valid  in  1  vd_write_back holds a packet to enqueue.
- wb_ready  out  1  queue can accept a packet this cycle.
- vd_write_back  in  data_packet_t  tag = destination vreg index, data = 64-bit merged result.
- rf_write_enable  out  1  register file write request valid.
- rf_write_ready  in  1  register file accepts the write this cycle.
- rf_write_address  out  VREG_TAG_WIDTH  destination vreg (head tag).
- rf_write_data  out  64  write data (head data).
- busy_tags  out  VREG_COUNT  bit i set while any queued entry targets vreg i.
- pending_count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal; full = indices equal and wrap bits differ.
- Reset (async, reset_n=0):
  - Both pointers cleared.
  - Outputs: pending_count=0, busy_tags=0, rf_write_enable=0, wb_ready=1.
  - Storage contents are don't-care.
- Handshake rules:
  - push = wb_valid & wb_ready.
  - pop = rf_write_enable & rf_write_ready.
  - wb_ready = !full. It has no combinational dependence on rf_write_ready, so a full queue refuses input even in a cycle where it pops.
  - rf_write_enable = !empty. rf_write_address and rf_write_data are driven from the head entry and stay stable while rf_write_enable=1 and rf_write_ready=0.
- Latency: a packet pushed at edge N appears on rf_write_* in cycle N+1 at the earliest (non-bypass build).
- Simultaneous push and pop:
  - Both pointers advance and pending_count is unchanged.
  - Legal in every non-full state, including the single-entry state where the head is replaced.
- Wrap-around: pointers increment modulo 2*DEPTH. Ordering is strictly FIFO across the wrap.
- Flush:
  - On a clock edge with flush=1, both pointers are set to the write pointer value, so the queue becomes empty.
  - A push in the same cycle is dropped; flush wins.
  - A pop in the same cycle still reaches the register file (the write already handshook) but is not re-counted.
- busy_tags: combinational OR over all occupied entries of the one-hot decode of their tag. Duplicate tags are allowed; the bit clears only when no occupied entry holds that tag.
- pending_count = write pointer minus read pointer, computed modulo 2*DEPTH.
- Reset mid-operation: all queued entries are lost with no register file write. Outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: VECTOR_WRITE_BACK_QUEUE_BYPASS_EN.
- Defined, and queue empty with wb_valid=1:
  - vd_write_back drives rf_write_* combinationally with rf_write_enable=1, giving zero latency.
  - If rf_write_ready=1, the packet is not stored.
  - If rf_write_ready=0, it is pushed normally.
  - busy_tags includes the bypassed tag during that cycle.
- Undefined: the behaviour above only; minimum latency is 1 cycle.

Decomposition:
- dragonfang_pkg gains VREG_COUNT, VREG_TAG_WIDTH=$clog2(VREG_COUNT), and WB_QUEUE_DEPTH. The existing data_packet_t is reused unchanged.
- One sub-module: vector_fifo_core, a generic parameterised FIFO providing storage, pointers, full/empty and count.
- vector_write_back_queue adds the handshake, flush, busy_tags decode and bypass logic on top of it.

Test Plan:
- Fill: after reset, push tags 1,2,3,4 (data 0x11..,0x22..,0x33..,0x44..) with rf_write_ready=0 -> full, wb_ready=0, pending_count=4, busy_tags=0x1E, rf_write_address=1 held stable.
- Drain with wrap: continue 10 push/pop cycles (push and pop every cycle) -> outputs leave in push order, pending_count stays constant, pointers wrap with no loss.
- Flush: queue holds 3 entries, assert flush together with push of tag 7 -> next cycle pending_count=0, busy_tags=0, rf_write_enable=0, tag 7 never written.
- Duplicate tags: push tag 5 twice, pop one -> busy_tags bit 5 still 1; pop second -> bit 5 clears.
- Async reset: assert reset_n=0 mid-cycle with 2 entries queued -> rf_write_enable=0 and pending_count=0 before the next edge; wb_ready=1.
- Bypass (macro defined): queue empty, push tag 9 with rf_write_ready=1 -> rf_write_enable=1, address=9 in the same cycle, pending_count stays 0. Macro undefined: address=9 appears one cycle later.
